calc_display: RTL and testbench
===============================

# calc_display

- Receiving end of the calculator's digit-print stream.
- Samples the `status`/`data`/`pos` outputs of the calculator core while a print is in progress, assembles eight BCD digits in a shadow buffer, and commits the complete frame atomically to a display buffer.
- Time-multiplexes the display buffer onto an 8-digit common-anode seven-segment display.
- Also renders the error indication when the core reports status `00`.

## Interface
Parameters:
- `CLK_DIV`, default 50000: clock cycles each digit stays lit per scan slot; legal range ≥ 2.
- `NUM_DIGITS`, default 8: number of display digits; fixed at 8 by the stream protocol, exposed for the package only.

Ports:
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `status` in 2: core status. `00` = error, `01` = busy, `10` = ready, `11` = printing.
- `data` in 4: BCD digit accompanying `pos`.
- `pos` in 4: stream index. Values 1..8 mean `data` is digit `pos-1` (digit 0 = least significant). Value 0 = no digit.
- `an` out 8: digit enables, active-low, one-hot-low while scanning.
- `seg` out 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `dp` out 1: decimal point, active-low, always 1.
- `frame_ok` out 1: one-cycle pulse on each frame commit.

## Operation
Capture:
- A digit is captured in a cycle where `status==11` and `1 ≤ pos ≤ 8`.
- On capture: `shadow[pos-1] <= data` and `mask[pos-1] <= 1`.
- `pos` = 0 or 9..15 is ignored, including while `status==11`.
- `data` > 9 is stored as-is and rendered blank.

Commit:
- A commit happens in the cycle where registered `status` was `11` and input `status` is not `11`, with `mask==8'hFF`.
- On commit: `disp <= shadow`, `frame_ok` pulses, `mask` clears.
- Leaving `11` with `mask` incomplete discards the partial frame: `mask` clears and `disp` is unchanged.
- Same-cycle capture and commit cannot occur, since commit requires `status≠11`.

Error:
- While input `status==00`, the error pattern overrides `disp`.
- Digits 3..0 show "Erro"; digits 7..4 are blank.
- `disp` is preserved and returns once `status≠00`.

Scan:
- Prescaler counts 0..`CLK_DIV-1`. At terminal count, the digit index increments mod 8 (7 wraps to 0).
- `an[idx]=0`; all other `an` bits are 1.
- `seg` = decode(selected symbol).

Reset (`reset=0`), asynchronous:
- `shadow`, `disp` = 0; `mask` = 0.
- Prescaler and index = 0.
- `an=8'hFF`, `seg=7'h7F`, `dp=1`, `frame_ok=0`.
- Reset mid-frame drops all captured digits.

## Timing
- Capture and `disp` are registered.
- `frame_ok` is high during the cycle after the commit-condition cycle; `disp` holds the new frame in that same cycle.
- `an`/`seg` are registered from `idx`/`disp`. The first cycle after reset release is blanked (`an=FF`), and the digit 0 slot starts at the next cycle.
- A `disp` change appears on `seg` one cycle later, in whichever slot is active. There is no tearing, because `disp` only changes as a whole.
- Error override: `seg` reflects the error pattern one cycle after `status` becomes `00`.
- Full refresh period = 8·`CLK_DIV` cycles.

## Configuration
Macro `CALC_DISP_LZ_BLANK_EN`:
- Defined: leading zeros are blanked. A digit `i>0` is blank when all digits `i..7` of `disp` are 0. Digit 0 always shows, so 0 displays as a single "0".
- Not defined: all eight digits are rendered, with zeros shown.
- The error pattern is unaffected either way.

## Structure
Package `calc_disp_pkg` contains:
- Status constants: `ST_ERR`, `ST_BUSY`, `ST_READY`, `ST_PRINT`.
- Symbol enum: digits 0–9, `SYM_E`, `SYM_R`, `SYM_O`, `SYM_BLANK`.
- Active-low segment code constants.
- `NUM_DIGITS`.

Sub-module `seg7_decoder`:
- Combinational, symbol → 7-bit active-low segments.
- Instantiated once on the scan path.

## Test plan
- Reset held low → `an=FF`, `seg=7F`, `frame_ok=0`. Release reset → `an` walks `FE,FD,…,7F,FE`, advancing every `CLK_DIV` cycles (bench uses `CLK_DIV=4`).
- Print frame (`status=11`, `pos=0` then `pos` 1..8 with `data` 3,2,1,0,0,0,0,0), then `status=10` → `frame_ok` pulses once.
  - Macro on: digits 0–2 show 3,2,1 (value 123); digits 3–7 blank.
  - Macro off: digits 3–7 show `0`.
- Frame aborted after `pos=4` (`status` → 10) → no `frame_ok`; display keeps the previous 123.
- `status=00` → digits 3..0 show E,r,r,o and digits 7..4 blank. `status` back to 10 → 123 restored.
- Reset asserted mid-frame at `pos=5`, released, then a full frame of all 9s → no commit before reset; afterwards displays 99999999 with one `frame_ok`.
- `data=4'hC` at `pos=1` in an otherwise-zero frame → digit 0 blank, `frame_ok` pulses.

Source files
------------

// File: rtl/calc_disp_pkg.sv
// Shared constants for the calculator display: core status codes, display symbols
// and active-low seven-segment codes ({g,f,e,d,c,b,a}).
package calc_disp_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [1:0] ST_ERR   = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;
    localparam logic [1:0] ST_PRINT = 2'b11;

    typedef enum logic [3:0] {
        SYM_0, SYM_1, SYM_2, SYM_3, SYM_4, SYM_5, SYM_6, SYM_7, SYM_8, SYM_9,
        SYM_E, SYM_R, SYM_O, SYM_BLANK
    } sym_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_O     = 7'h23;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Non-BCD digit values render as blank rather than garbage segments.
    function automatic sym_t digit_sym(input logic [3:0] d);
        return (d <= 4'd9) ? sym_t'(d) : SYM_BLANK;
    endfunction

endpackage

// File: rtl/calc_display_seg7_decoder.sv
// Combinational symbol to active-low seven-segment decoder.
module seg7_decoder
    import calc_disp_pkg::*;
(
    input  sym_t       sym,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (sym)
            SYM_0:   seg = SEG_0;
            SYM_1:   seg = SEG_1;
            SYM_2:   seg = SEG_2;
            SYM_3:   seg = SEG_3;
            SYM_4:   seg = SEG_4;
            SYM_5:   seg = SEG_5;
            SYM_6:   seg = SEG_6;
            SYM_7:   seg = SEG_7;
            SYM_8:   seg = SEG_8;
            SYM_9:   seg = SEG_9;
            SYM_E:   seg = SEG_E;
            SYM_R:   seg = SEG_R;
            SYM_O:   seg = SEG_O;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/calc_display.sv
// Captures the core's digit-print stream into a shadow frame, commits it atomically,
// and scans it onto an 8-digit common-anode display. Optional: CALC_DISP_LZ_BLANK_EN.
module calc_display
    import calc_disp_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] status,
    input  logic [3:0] data,
    input  logic [3:0] pos,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_ok
);

    localparam int CW = $clog2(CLK_DIV);

    logic [NUM_DIGITS-1:0][3:0] shadow, disp;
    logic [NUM_DIGITS-1:0]      mask;
    logic [1:0]                 status_q;
    logic [CW-1:0]              presc;
    logic [2:0]                 idx;
    logic [3:0]                 pos_m1;
    logic                       capture, commit;
    logic [NUM_DIGITS-1:0]      lz;
    sym_t                       sym;
    logic [6:0]                 seg_dec;

    assign pos_m1  = pos - 4'd1;
    assign capture = (status == ST_PRINT) && (pos >= 4'd1) && (pos <= 4'd8);
    assign commit  = (status_q == ST_PRINT) && (status != ST_PRINT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow   <= '0;
            disp     <= '0;
            mask     <= '0;
            status_q <= ST_ERR;
            frame_ok <= 1'b0;
        end else begin
            status_q <= status;
            frame_ok <= 1'b0;
            if (capture) begin
                shadow[pos_m1[2:0]] <= data;
                mask[pos_m1[2:0]]   <= 1'b1;
            end
            // Leaving the print state always ends the frame; only a full mask publishes it.
            if (commit) begin
                mask <= '0;
                if (&mask) begin
                    disp     <= shadow;
                    frame_ok <= 1'b1;
                end
            end
        end
    end

`ifdef CALC_DISP_LZ_BLANK_EN
    always_comb begin
        logic run;
        lz  = '0;
        run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            run   = run && (disp[i] == 4'd0);
            lz[i] = run;
        end
    end
`else
    assign lz = '0;
`endif

    always_comb begin
        sym = SYM_BLANK;
        if (status == ST_ERR) begin
            case (idx)
                3'd3:    sym = SYM_E;
                3'd2:    sym = SYM_R;
                3'd1:    sym = SYM_R;
                3'd0:    sym = SYM_O;
                default: sym = SYM_BLANK;
            endcase
        end else if (!lz[idx]) begin
            sym = digit_sym(disp[idx]);
        end
    end

    seg7_decoder u_dec (
        .sym (sym),
        .seg (seg_dec)
    );

    // an/seg are registered so the first post-reset cycle stays blank.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc <= '0;
            idx   <= '0;
            an    <= 8'hFF;
            seg   <= SEG_BLANK;
        end else begin
            if (presc == CW'(CLK_DIV - 1)) begin
                presc <= '0;
                idx   <= idx + 3'd1;
            end else begin
                presc <= presc + CW'(1);
            end
            an  <= ~(8'b1 << idx);
            seg <= seg_dec;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_calc_display.sv
// Scoreboard bench for calc_display: expected frames are queued as prints are sent
// and compared against the scanned display when frame_ok fires.
module tb_calc_display;

    localparam int DIV = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] status = 2'b10;
    logic [3:0] data = '0;
    logic [3:0] pos = '0;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_ok;

    int n_chk = 0;
    int n_err = 0;
    int fok_cnt = 0;
    logic [55:0] sb_q[$];
    logic [55:0] last_exp;

    calc_display #(.CLK_DIV(DIV)) dut (
        .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
        .an(an), .seg(seg), .dp(dp), .frame_ok(frame_ok)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (frame_ok) fok_cnt++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40; 4'd1: return 7'h79; 4'd2: return 7'h24; 4'd3: return 7'h30;
            4'd4: return 7'h19; 4'd5: return 7'h12; 4'd6: return 7'h02; 4'd7: return 7'h78;
            4'd8: return 7'h00; 4'd9: return 7'h10; default: return 7'h7F;
        endcase
    endfunction

    // Expected scanned segments for a committed frame (digit k at bits 7k+:7).
    function automatic logic [55:0] exp_frame(input logic [31:0] d);
        logic [55:0] r;
        bit run;
        run = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            run = run && (d[4*i+:4] == 4'd0);
            r[7*i+:7] = seg_of(d[4*i+:4]);
`ifdef CALC_DISP_LZ_BLANK_EN
            if (i > 0 && run) r[7*i+:7] = 7'h7F;
`endif
        end
        return r;
    endfunction

    task automatic read_disp(output logic [55:0] s);
        logic [7:0] seen;
        logic [7:0] sel;
        s = '1;
        seen = '0;
        repeat (2) @(negedge clock);
        for (int c = 0; c < 2 * 8 * DIV; c++) begin
            @(negedge clock);
            for (int k = 0; k < 8; k++) begin
                sel = ~(8'b1 << k);
                if (an == sel) begin
                    s[7*k+:7] = seg;
                    seen[k] = 1'b1;
                end
            end
        end
        chk("scan_all_digits", {56'd0, seen}, 64'hFF);
    endtask

    task automatic send_frame(input logic [31:0] d, input int last, input bit finish);
        @(negedge clock);
        status = 2'b11; pos = 4'd0; data = 4'd7;
        @(negedge clock);
        pos = 4'd12; data = 4'd5;               // out-of-range index must be ignored
        for (int p = 1; p <= last; p++) begin
            @(negedge clock);
            pos = 4'(p);
            data = d[4*(p-1)+:4];
        end
        if (finish) begin
            @(negedge clock);
            status = 2'b10; pos = 4'd0; data = 4'd0;
        end
    endtask

    task automatic expect_commit(input string tag);
        logic [55:0] got, exp;
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clock);
            if (frame_ok) seen = 1'b1;
        end
        chk({tag, "_frame_ok"}, {63'd0, seen}, 64'd1);
        @(negedge clock);
        chk({tag, "_frame_ok_one_cycle"}, {63'd0, frame_ok}, 64'd0);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            exp = sb_q.pop_front();
            last_exp = exp;
            read_disp(got);
            chk({tag, "_display"}, {8'd0, got}, {8'd0, exp});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [55:0] got;
        logic [55:0] err_pat;
        int base;

        repeat (3) @(negedge clock);
        chk("rst_an", {56'd0, an}, 64'hFF);
        chk("rst_seg", {57'd0, seg}, 64'h7F);
        chk("rst_dp", {63'd0, dp}, 64'd1);
        chk("rst_frame_ok", {63'd0, frame_ok}, 64'd0);

        reset = 1'b1;
        #1 chk("first_cycle_blank", {56'd0, an}, 64'hFF);
        for (int n = 0; n < 9 * DIV; n++) begin
            @(negedge clock);
            chk("an_walk", {56'd0, an}, {56'd0, ~(8'b1 << ((n / DIV) % 8))});
        end

        // 123 frame
        send_frame(32'h0000_0123, 8, 1'b1);
        sb_q.push_back(exp_frame(32'h0000_0123));
        expect_commit("f123");
        chk("fok_cnt_1", 64'(fok_cnt), 64'd1);

        // aborted frame after pos 4 keeps the previous display
        send_frame(32'h8888_8888, 4, 1'b1);
        read_disp(got);
        chk("abort_no_commit", 64'(fok_cnt), 64'd1);
        chk("abort_display", {8'd0, got}, {8'd0, last_exp});

        // error override then restore
        @(negedge clock) status = 2'b00;
        err_pat = {{4{7'h7F}}, 7'h06, 7'h2F, 7'h2F, 7'h23};
        read_disp(got);
        chk("err_display", {8'd0, got}, {8'd0, err_pat});
        @(negedge clock) status = 2'b10;
        read_disp(got);
        chk("err_restore", {8'd0, got}, {8'd0, last_exp});

        // reset mid-frame drops the partial frame
        base = fok_cnt;
        send_frame(32'h9999_9999, 5, 1'b0);
        @(negedge clock);
        reset = 1'b0; status = 2'b10; pos = 4'd0;
        #1 chk("midrst_an", {56'd0, an}, 64'hFF);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        chk("midrst_no_commit", 64'(fok_cnt), 64'(base));
        read_disp(got);
        chk("midrst_display_zero", {8'd0, got}, {8'd0, exp_frame(32'h0)});

        send_frame(32'h9999_9999, 8, 1'b1);
        sb_q.push_back(exp_frame(32'h9999_9999));
        expect_commit("f9s");
        chk("fok_cnt_9s", 64'(fok_cnt), 64'(base + 1));

        // non-BCD digit renders blank
        send_frame(32'h0000_000C, 8, 1'b1);
        sb_q.push_back(exp_frame(32'h0000_000C));
        expect_commit("fC");
        chk("fok_cnt_C", 64'(fok_cnt), 64'(base + 2));

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
